sram_like_data_resp: RTL

Responder (slave) end of the sram-like data-memory handshake driven by the CPU's execute/memory stages: it accepts `req`/`addr_ok` address phases, performs the access on a local word-addressed memory, and returns one `data_ok`/`rdata` beat per accepted request, in order, after a fixed latency. It stands in for the data RAM in CPU-level simulation and is the checker-friendly model the pipeline's handshake is verified against. Up to DEPTH requests are outstanding; back-pressure is applied through `addr_ok` only.

---
 rtl/sram_like_data_resp.sv | 88 ++++++++
 1 files changed

// File: rtl/sram_like_data_resp.sv
// sram_like_data_resp: sram-like data-memory responder with fixed-latency, in-order data_ok/rdata beats.
module sram_like_data_resp #(
  parameter int    ADDR_W    = 12,
  parameter int    DEPTH     = 4,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  localparam cnt_t       FULL   = cnt_t'(DEPTH);
  localparam logic [3:0] LAST   = 4'(LATENCY - 1);
  localparam bit         BYPASS = (LATENCY == 1);

  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_dat [DEPTH];
  logic [3:0]        r_age [DEPTH];
  ptr_t              r_wp, r_rp;
  cnt_t              r_count;
  logic              r_ready, r_dok;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] w_idx;
  logic              w_go, w_acc, w_push, w_ret, w_unused;
  logic [31:0]       w_rd;

  assign w_idx    = addr[ADDR_W+1:2];
  assign w_unused = ^{size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef SRAM_RESP_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_lfsr <= 16'hACE1;
    else r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_go = r_lfsr[0];
`else
  assign w_go = 1'b1;
`endif

  assign addr_ok = r_ready & (r_count != FULL) & w_go;
  assign w_acc   = req & addr_ok;
  assign w_push  = w_acc & ~BYPASS;
  assign w_ret   = ~BYPASS & (r_count != '0) & (r_age[r_rp] == LAST);
  assign w_rd    = wr ? '0 : r_mem[w_idx];

  always_ff @(posedge clk)
    if (w_acc && wr)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];

  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (w_push && ptr_t'(i) == r_wp) begin
        r_dat[i] <= w_rd;
        r_age[i] <= 4'd1;
      end else r_age[i] <= r_age[i] + 4'd1;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_ready <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_dok   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= 1'b1;
      r_wp    <= r_wp + ptr_t'(w_push);
      r_rp    <= r_rp + ptr_t'(w_ret);
      r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_ret);
      r_dok   <= BYPASS ? w_acc : w_ret;
      r_rdata <= BYPASS ? (w_acc ? w_rd : '0) : (w_ret ? r_dat[r_rp] : '0);
    end

  assign data_ok = r_dok;
  assign rdata   = r_rdata;
endmodule
